// File: rtl/m_prim_lib_pkg.sv
// Shared definitions for the primitive library: counter operation decode.
// Ports: none (package only).
// The decode gives load priority over counting, and ignores direction when not counting.
package m_prim_lib_pkg;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_LOAD = 2'd1,
        CNT_INC  = 2'd2,
        CNT_DEC  = 2'd3
    } cnt_op_t;

    // Load beats count; direction only matters when counting.
    function automatic cnt_op_t cnt_op_decode(input logic load, input logic en, input logic up);
        if (load)
            return CNT_LOAD;
        else if (en)
            return up ? CNT_INC : CNT_DEC;
        else
            return CNT_HOLD;
    endfunction

endpackage

// File: rtl/m_adder.sv
// Unsigned WIDTH-bit adder with carry-in/carry-out; combinational, zero latency.
// Ports: sum/cout results, A/B operands, cin carry-in.
// Subtraction: feed B = ~x and cin = 1; cout is then the no-borrow flag.
module m_adder #(
    parameter int WIDTH = 14
) (
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin
);

    // Extend to WIDTH+1 bits so the carry lands in the top bit.
    assign {cout, sum} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/m_comparator.sv
// Unsigned magnitude comparator; combinational, zero latency.
// Ports: AltB/AeqB/AgtB flags (exactly one set), A/B operands.
// Operands are treated as unsigned magnitudes.
module m_comparator #(
    parameter int WIDTH = 14
) (
    output logic             AltB,
    output logic             AeqB,
    output logic             AgtB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B
);

    assign AltB = (A <  B);
    assign AeqB = (A == B);
    assign AgtB = (A >  B);

endmodule

// File: rtl/m_counter.sv
// Loadable up/down counter, wraps modulo 2^WIDTH; 1-cycle latency from controls.
// Ports: Q count, D load value, clk, clr (sync active-high), load, up, en.
// Priority per edge: clr, then load, then count (en with up/down), else hold.
module m_counter
    import m_prim_lib_pkg::*;
#(
    parameter int WIDTH = 14
) (
    output logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] D,
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             up,
    input  logic             en
);

    always_ff @(posedge clk) begin
        if (clr) begin
            Q <= '0;
        end else begin
            // Natural WIDTH-bit overflow provides the required wrap-around.
            unique case (cnt_op_decode(load, en, up))
                CNT_LOAD: Q <= D;
                CNT_INC:  Q <= Q + WIDTH'(1);
                CNT_DEC:  Q <= Q - WIDTH'(1);
                default:  Q <= Q;
            endcase
        end
    end

endmodule

// File: rtl/m_prim_lib.sv
// Primitive library top: one adder, one comparator, one counter side by side.
// Ports: add_* adder, cmp_* comparator (both combinational), cnt_* counter, clk/rst.
// rst is synchronous active-high and clears only the counter.
module m_prim_lib #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] add_a,
    input  logic [WIDTH-1:0] add_b,
    input  logic             add_cin,
    output logic [WIDTH-1:0] add_sum,
    output logic             add_cout,
    input  logic [WIDTH-1:0] cmp_a,
    input  logic [WIDTH-1:0] cmp_b,
    output logic             cmp_lt,
    output logic             cmp_eq,
    output logic             cmp_gt,
    input  logic [WIDTH-1:0] cnt_d,
    input  logic             cnt_load,
    input  logic             cnt_up,
    input  logic             cnt_en,
    output logic [WIDTH-1:0] cnt_q
);

    m_adder #(.WIDTH(WIDTH)) u_adder (
        .sum  (add_sum),
        .cout (add_cout),
        .A    (add_a),
        .B    (add_b),
        .cin  (add_cin)
    );

    m_comparator #(.WIDTH(WIDTH)) u_comparator (
        .AltB (cmp_lt),
        .AeqB (cmp_eq),
        .AgtB (cmp_gt),
        .A    (cmp_a),
        .B    (cmp_b)
    );

    m_counter #(.WIDTH(WIDTH)) u_counter (
        .Q    (cnt_q),
        .D    (cnt_d),
        .clk  (clk),
        .clr  (rst),
        .load (cnt_load),
        .up   (cnt_up),
        .en   (cnt_en)
    );

endmodule

// File: tb/tb_m_prim_lib.sv
// Testbench for m_prim_lib: directed boundary cases plus random traffic.
// Stimulus pushes expected responses into a queue; a negedge monitor pops and compares.
// Reference model uses plain integer arithmetic modulo 2^WIDTH.
module tb_m_prim_lib;

    localparam int W   = 14;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic [W-1:0] cmp_a, cmp_b;
    logic         cmp_lt, cmp_eq, cmp_gt;
    logic [W-1:0] cnt_d, cnt_q;
    logic         cnt_load, cnt_up, cnt_en;

    m_prim_lib #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
        .cnt_d(cnt_d), .cnt_load(cnt_load), .cnt_up(cnt_up), .cnt_en(cnt_en),
        .cnt_q(cnt_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int cout;
        int lt;
        int eq;
        int gt;
        int cnt;
        bit chk_cnt;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   model_cnt = 0;
    bit   cnt_known = 1'b0;

    task automatic check(input string name, input int act, input int req, input string tag);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s [%s]: got %0d, expected %0d", name, tag, act, req);
    endtask

    // Drive one cycle's inputs just after the rising edge, then record expectations.
    task automatic drive(input string tag, input int a, input int b, input int cin,
                         input int ca, input int cb, input int d,
                         input int ld, input int up, input int en, input int r);
        exp_t e;
        int   s;
        @(posedge clk);
        #1;
        add_a = W'(a); add_b = W'(b); add_cin = cin[0];
        cmp_a = W'(ca); cmp_b = W'(cb);
        cnt_d = W'(d); cnt_load = ld[0]; cnt_up = up[0]; cnt_en = en[0]; rst = r[0];
        s = (a % MOD) + (b % MOD) + cin;
        e.sum  = s % MOD;
        e.cout = s / MOD;
        e.lt   = (ca % MOD) < (cb % MOD) ? 1 : 0;
        e.eq   = (ca % MOD) == (cb % MOD) ? 1 : 0;
        e.gt   = (ca % MOD) > (cb % MOD) ? 1 : 0;
        e.cnt  = model_cnt;
        e.chk_cnt = cnt_known;
        e.tag  = tag;
        exp_q.push_back(e);
        // Counter state the next edge will produce.
        if (r != 0) begin
            model_cnt = 0;
            cnt_known = 1'b1;
        end else if (ld != 0) model_cnt = d % MOD;
        else if (en != 0) model_cnt = (up != 0) ? (model_cnt + 1) % MOD : (model_cnt + MOD - 1) % MOD;
    endtask

    // Monitor: outputs are valid every cycle; compare at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("add_sum",  int'(add_sum),  e.sum,  e.tag);
                check("add_cout", int'(add_cout), e.cout, e.tag);
                check("cmp_lt",   int'(cmp_lt),   e.lt,   e.tag);
                check("cmp_eq",   int'(cmp_eq),   e.eq,   e.tag);
                check("cmp_gt",   int'(cmp_gt),   e.gt,   e.tag);
                if (e.chk_cnt) check("cnt_q", int'(cnt_q), e.cnt, e.tag);
            end
        end
    end

    initial begin
        int wait_cycles;
        int a, b, ca, cb, d, ld, up, en, r;
        rst = 1'b1; add_a = '0; add_b = '0; add_cin = 1'b0; cmp_a = '0; cmp_b = '0;
        cnt_d = '0; cnt_load = 1'b0; cnt_up = 1'b0; cnt_en = 1'b0;

        // Reset, then adder and comparator corner cases while the counter idles.
        drive("reset",    0,     0,  0, 0,   0,     0, 0, 0, 0, 1);
        drive("add_wrap", 16383, 1,  0, 640, 320,   0, 0, 0, 0, 0);
        drive("sub_5_3",  5,     16383 - 3, 1, 200, 200, 0, 0, 0, 0, 0);
        drive("sub_3_5",  3,     16383 - 5, 1, 0,   16383, 0, 0, 0, 0, 0);
        drive("add_max",  16383, 16383, 1, 16383, 0, 0, 0, 0, 0, 0);

        // Reset then count up five times: 0,1,2,3,4,5.
        drive("rst1", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 6; i++) drive("count_up", i, i, 0, i, 5, 0, 0, 1, 1, 0);

        // Load wins over enable; then wrap up through all-ones to zero.
        drive("load_vs_en", 1, 2, 0, 1, 2, 16382, 1, 1, 1, 0);
        drive("wrap_up",    1, 2, 0, 1, 2, 0,     0, 1, 1, 0);
        drive("wrap_up",    1, 2, 0, 1, 2, 0,     0, 1, 1, 0);
        drive("wrap_chk",   1, 2, 0, 1, 2, 0,     0, 0, 0, 0);

        // From zero count down to all-ones, then hold three cycles with up toggling.
        drive("wrap_down",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive("hold",       0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive("hold",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("hold",       0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Counting from 100, reset mid-count overrides load/en, then resume from 0.
        drive("load100",    0, 0, 0, 0, 0, 100, 1, 1, 1, 0);
        drive("up_101",     0, 0, 0, 0, 0, 0,   0, 1, 1, 0);
        drive("rst_mid",    0, 0, 0, 0, 0, 77,  1, 1, 1, 1);
        drive("resume",     0, 0, 0, 0, 0, 0,   0, 1, 1, 0);
        drive("resume",     0, 0, 0, 0, 0, 0,   0, 1, 1, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            a  = $urandom_range(0, MOD - 1);
            b  = ($urandom_range(0, 7) == 0) ? MOD - 1 - a : $urandom_range(0, MOD - 1);
            ca = $urandom_range(0, MOD - 1);
            cb = ($urandom_range(0, 3) == 0) ? ca : $urandom_range(0, MOD - 1);
            d  = ($urandom_range(0, 1) == 0) ? $urandom_range(MOD - 3, MOD - 1) : $urandom_range(0, 3);
            ld = ($urandom_range(0, 7) == 0) ? 1 : 0;
            up = $urandom_range(0, 1);
            en = ($urandom_range(0, 3) != 0) ? 1 : 0;
            r  = ($urandom_range(0, 31) == 0) ? 1 : 0;
            drive("random", a, b, $urandom_range(0, 1), ca, cb, d, ld, up, en, r);
        end

        // Let the monitor drain the queue, bounded.
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/m_prim_lib.md
M_PRIM_LIB -- requirements
Module: m_prim_lib

Interface
REQ-001 The module SHALL have parameter WIDTH, default 14, giving the width of all data buses.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset: synchronous, active-high; clears the counter.
REQ-004 add_a, add_b  input  WIDTH  adder operands, unsigned.
REQ-005 add_cin  input  1  adder carry-in.
REQ-006 add_sum  output  WIDTH  adder sum.
REQ-007 add_cout  output  1  adder carry-out.
REQ-008 cmp_a, cmp_b  input  WIDTH  comparator operands, unsigned.
REQ-009 cmp_lt, cmp_eq, cmp_gt  output  1 each  a<b, a==b, a>b.
REQ-010 cnt_d  input  WIDTH  counter load value.
REQ-011 cnt_load  input  1  synchronous load of cnt_d.
REQ-012 cnt_up  input  1  count direction: 1 = up, 0 = down.
REQ-013 cnt_en  input  1  count enable.
REQ-014 cnt_q  output  WIDTH  registered counter value.

Function
REQ-015 {add_cout, add_sum} SHALL equal add_a + add_b + add_cin, computed at WIDTH+1 bits, purely combinational, zero latency.
REQ-016 The adder SHALL act as a two's-complement subtractor when given add_b = ~x and add_cin = 1; add_cout is then the unsigned no-borrow flag.
REQ-017 Exactly one of cmp_lt, cmp_eq, cmp_gt SHALL be 1 for any input pair, using unsigned magnitude comparison, combinational.
REQ-018 On each rising clk edge the counter SHALL apply this priority: rst -> 0; else cnt_load -> cnt_d; else cnt_en & cnt_up -> cnt_q+1; else cnt_en & ~cnt_up -> cnt_q-1; else hold.
REQ-019 Counter arithmetic SHALL wrap modulo 2^WIDTH: all-ones+1 -> 0, and 0-1 -> all-ones.
REQ-020 When cnt_load and cnt_en are both 1, the load SHALL win and no count occurs that cycle.
REQ-021 cnt_q SHALL change only on a clock edge, with 1-cycle latency from the control inputs.
REQ-022 cnt_up SHALL be ignored when cnt_en=0 or cnt_load=1.

Reset
REQ-023 rst SHALL be sampled only on the rising clk edge and SHALL override cnt_load and cnt_en.
REQ-024 After reset cnt_q SHALL be 0; add_* and cmp_* outputs, being combinational, SHALL have no reset state.
REQ-025 Asserting rst mid-count SHALL force cnt_q to 0 on the next edge, and counting SHALL resume from 0 on the edge after rst deasserts.

Structure
REQ-026 The design SHALL consist of three parameterized sub-modules, m_adder (ports sum, cout, A, B, cin), m_comparator (ports AltB, AeqB, AgtB, A, B) and m_counter (ports Q, D, clk, clr, load, up, en), each parameter WIDTH; m_prim_lib instantiates one of each and wires rst to clr.
REQ-027 No shared package is required; WIDTH is the only constant.
REQ-028 The sub-modules SHALL be reusable standalone, and their positional port order SHALL be exactly as listed in REQ-026.

Verification
REQ-029 WIDTH=14, add_a=14'h3FFF, add_b=1, add_cin=0 -> add_sum=0, add_cout=1; add_a=5, add_b=~3, add_cin=1 -> add_sum=2, add_cout=1.
REQ-030 cmp_a=640, cmp_b=320 -> gt=1, eq=0, lt=0; cmp_a=cmp_b=200 -> eq only; cmp_a=0, cmp_b=14'h3FFF -> lt only.
REQ-031 rst=1 one cycle, then cnt_en=1, cnt_up=1 for 5 cycles -> cnt_q steps 0,1,2,3,4,5.
REQ-032 cnt_load=1 with cnt_d=14'h3FFE and cnt_en=1 -> cnt_q=14'h3FFE, not 14'h3FFF; then counting up 2 cycles -> 14'h3FFF, 0.
REQ-033 cnt_q=0, cnt_en=1, cnt_up=0 -> cnt_q=14'h3FFF; cnt_en=0 for 3 cycles -> cnt_q holds.
REQ-034 Counting up at cnt_q=100 with rst=1 for one cycle -> cnt_q=0 next edge; rst=0 -> cnt_q=1 the following edge.
